// File: rtl/serdes_pkg.sv
// Shared types and constants for the serial link blocks.
package serdes_pkg;

  localparam int SERDES_W = 16;
  localparam logic [SERDES_W-1:0] DEFAULT_SYNC_WORD = 16'hBC1C;

  typedef enum logic {HUNT, LOCKED} deser_state_t;

endpackage

// File: rtl/sync_detector.sv
// Sliding 16-bit window over the serial stream; flags when the window,
// including the bit being shifted in this edge, equals the sync word.
module sync_detector
  import serdes_pkg::*;
#(
  parameter logic [SERDES_W-1:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic shift_en,
  input  logic clear,
  input  logic sdata,
  output logic match
);

  logic [SERDES_W-1:0] window;
  logic [SERDES_W-1:0] next_window;

  assign next_window = {window[SERDES_W-2:0], sdata};
  assign match       = shift_en && (next_window == SYNC_WORD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window <= '0;
    end else if (clear) begin
      window <= '0;
    end else if (shift_en) begin
      window <= next_window;
    end
  end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel deserializer with sync-word framing and loss-of-lock.
// Define DESER_STATS_EN to build the word_cnt / err_cnt statistics counters.
module deserializer
  import serdes_pkg::*;
#(
  parameter logic [SERDES_W-1:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
  parameter int                  SYNC_INTERVAL = 8,
  parameter int                  MAX_MISS      = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sdata,
  input  logic                sdata_valid,
  output logic [SERDES_W-1:0] pdata,
  output logic                pdata_valid,
  output logic                locked,
  output logic                sync_err,
  output logic [15:0]         word_cnt,
  output logic [7:0]          err_cnt
);

  localparam int PAY_W  = 8;
  localparam int MISS_W = 3;

  deser_state_t        state;
  logic [3:0]          bit_cnt;
  logic [PAY_W-1:0]    pay_cnt;
  logic [MISS_W-1:0]   miss_cnt;
  logic [SERDES_W-1:0] word_sr;
  logic [SERDES_W-1:0] full_word;
  logic                hunting;
  logic                sync_match;

  assign hunting   = (state == HUNT);
  assign full_word = {word_sr[SERDES_W-2:0], sdata};

  // The window only runs while hunting and is held cleared while locked,
  // so a return to HUNT always starts from an empty window.
  sync_detector #(
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_detector (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (hunting && sdata_valid),
    .clear    (!hunting),
    .sdata    (sdata),
    .match    (sync_match)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      bit_cnt     <= '0;
      pay_cnt     <= '0;
      miss_cnt    <= '0;
      word_sr     <= '0;
      pdata       <= '0;
      pdata_valid <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      pdata_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (sdata_valid) begin
        case (state)
          HUNT: begin
            if (sync_match) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              bit_cnt  <= '0;
              pay_cnt  <= '0;
              miss_cnt <= '0;
              word_sr  <= '0;
            end
          end
          LOCKED: begin
            word_sr <= full_word;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              if (pay_cnt < PAY_W'(SYNC_INTERVAL)) begin
                pdata       <= full_word;
                pdata_valid <= 1'b1;
                pay_cnt     <= pay_cnt + 1'b1;
              end else begin
                // Sync slot: payload counter restarts the frame either way.
                pay_cnt <= '0;
                if (full_word == SYNC_WORD) begin
                  miss_cnt <= '0;
                end else begin
                  sync_err <= 1'b1;
                  if (miss_cnt == MISS_W'(MAX_MISS - 1)) begin
                    state    <= HUNT;
                    locked   <= 1'b0;
                    miss_cnt <= '0;
                  end else begin
                    miss_cnt <= miss_cnt + 1'b1;
                  end
                end
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef DESER_STATS_EN
  logic [15:0] word_cnt_q;
  logic [7:0]  err_cnt_q;

  // Counts follow the registered pulses; err_cnt sticks at its maximum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (pdata_valid) word_cnt_q <= word_cnt_q + 16'd1;
      if (sync_err && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign word_cnt = word_cnt_q;
  assign err_cnt  = err_cnt_q;
`else
  assign word_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: stimulus pushes expected words with their
// due cycle, a negedge monitor pops and compares on every pdata_valid.
module tb_deserializer;

  typedef struct {
    logic [15:0] word;
    int          due;
  } exp_t;

`ifdef DESER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sdata;
  logic        sdata_valid;
  logic [15:0] pdata;
  logic        pdata_valid;
  logic        locked;
  logic        sync_err;
  logic [15:0] word_cnt;
  logic [7:0]  err_cnt;

  int   compared      = 0;
  int   mismatched    = 0;
  int   neg_cnt       = 0;
  int   sync_err_seen = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  deserializer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sdata       (sdata),
    .sdata_valid (sdata_valid),
    .pdata       (pdata),
    .pdata_valid (pdata_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .word_cnt    (word_cnt),
    .err_cnt     (err_cnt)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: decoupled from stimulus, compares every delivered word.
  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    if (reset_n === 1'b1) begin
      if (pdata_valid && sync_err) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL pulse_overlap: got pdata_valid=1 sync_err=1, expected never both");
      end
      if (sync_err) sync_err_seen++;
      if (pdata_valid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no output", pdata);
        end else begin
          e = exp_q.pop_front();
          check_output("pdata", pdata, e.word);
          check_output("pdata_latency", neg_cnt, e.due);
        end
      end
    end
  end

  // Inputs change 1ns after a posedge; returns 1ns after the sampling edge.
  task automatic send_bit(input logic b, input logic v);
    sdata       = b;
    sdata_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input bit expect_out);
    for (int i = 15; i >= 0; i--) begin
      if (i == 0 && expect_out) exp_q.push_back('{word: w, due: neg_cnt + 2});
      send_bit(w[i], 1'b1);
    end
  endtask

  task automatic send_word_toggled(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      if (i == 0) exp_q.push_back('{word: w, due: neg_cnt + 2});
      send_bit(w[i], 1'b1);
      send_bit(~w[i], 1'b0);
    end
  endtask

  task automatic send_payload(input logic [15:0] base, input int first, input int last);
    for (int k = first; k <= last; k++) send_word(base + 16'(k), 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_pdata"}, pdata, 16'h0000);
    check_output({tag, "_pdata_valid"}, pdata_valid, 1'b0);
    check_output({tag, "_locked"}, locked, 1'b0);
    check_output({tag, "_sync_err"}, sync_err, 1'b0);
    check_output({tag, "_word_cnt"}, word_cnt, 16'h0000);
    check_output({tag, "_err_cnt"}, err_cnt, 8'h00);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n     = 1'b1;
    sdata       = 1'b0;
    sdata_valid = 1'b0;
    #1 reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    idle(2);

    $display("[TB] acquire lock and deliver one frame");
    send_word(16'hBC1C, 1'b0);
    check_output("locked_after_sync", locked, 1'b1);
    send_payload(16'h0000, 1, 8);
    send_word(16'hBC1C, 1'b0);
    check_output("locked_frame1", locked, 1'b1);
    check_output("pdata_hold", pdata, 16'h0008);

    $display("[TB] in-band sync word carried as payload");
    send_word(16'h0011, 1'b1);
    send_word(16'hBC1C, 1'b1);
    send_payload(16'h0010, 3, 8);
    send_word(16'hBC1C, 1'b0);
    check_output("locked_frame2", locked, 1'b1);
    check_output("sync_err_none", sync_err_seen, 0);

    $display("[TB] gapped word then three missed sync slots");
    send_word_toggled(16'h1234);
    send_payload(16'h0020, 2, 8);
    send_word(16'h0000, 1'b0);
    check_output("sync_err_pulse1", sync_err, 1'b1);
    check_output("locked_miss1", locked, 1'b1);
    send_payload(16'h0030, 1, 8);
    send_word(16'h0000, 1'b0);
    check_output("locked_miss2", locked, 1'b1);
    send_payload(16'h0040, 1, 8);
    send_word(16'h0000, 1'b0);
    check_output("sync_err_pulse3", sync_err, 1'b1);
    check_output("locked_lost", locked, 1'b0);
    idle(3);
    check_output("sync_err_total", sync_err_seen, 3);
    check_output("err_cnt", err_cnt, STATS ? 8'd3 : 8'd0);
    check_output("word_cnt", word_cnt, STATS ? 16'd40 : 16'd0);

    $display("[TB] lock on arbitrary bit alignment");
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    check_output("hunt_no_lock", locked, 1'b0);
    send_word(16'hBC1C, 1'b0);
    check_output("relock", locked, 1'b1);
    send_word(16'hA5A5, 1'b1);
    check_output("pdata_a5a5", pdata, 16'hA5A5);
    check_output("pdata_valid_a5a5", pdata_valid, 1'b1);

    $display("[TB] reset in the middle of a word");
    for (int i = 15; i >= 7; i--) send_bit(1'b1, 1'b1);
    reset_n = 1'b0;
    sdata_valid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    send_word(16'h1111, 1'b0);
    check_output("no_lock_after_reset", locked, 1'b0);
    send_word(16'hBC1C, 1'b0);
    check_output("lock_after_reset", locked, 1'b1);
    send_word(16'h2222, 1'b1);
    idle(3);
    check_output("word_cnt_after_reset", word_cnt, STATS ? 16'd1 : 16'd0);
    check_output("err_cnt_after_reset", err_cnt, 8'd0);
    check_output("sync_err_final", sync_err_seen, 3);
    check_output("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter SYNC_WORD, 16'hBC1C, alignment word searched for in the bit stream.
REQ-002 Parameter SYNC_INTERVAL, 8, payload words between consecutive sync words (1..255).
REQ-003 Parameter MAX_MISS, 3, consecutive missed sync words that force loss of lock (1..7).
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sdata  input  1  serial data bit, MSB of each word first.
REQ-007 sdata_valid  input  1  sdata is sampled only on edges where this is high; low = hold all state.
REQ-008 pdata  output  16  last recovered payload word; holds between updates.
REQ-009 pdata_valid  output  1  one-cycle pulse, pdata updated this cycle.
REQ-010 locked  output  1  high while in LOCKED state.
REQ-011 sync_err  output  1  one-cycle pulse on a missed sync word.
REQ-012 word_cnt  output  16  payload word count (DESER_STATS_EN only, else 0).
REQ-013 err_cnt  output  8  missed-sync count (DESER_STATS_EN only, else 0).

Function
REQ-014 FSM states HUNT and LOCKED shall be used; reset state HUNT.
REQ-015 HUNT: each valid bit shifts into a 16-bit window (new bit at LSB); when the window including the current bit equals SYNC_WORD, the FSM shall move to LOCKED next cycle with bit counter 0 and payload counter 0.
REQ-016 LOCKED: valid bits shall assemble into a word; the 16th bit completes the word.
REQ-017 Completed word, payload counter < SYNC_INTERVAL: pdata = word and pdata_valid = 1 on the cycle after the 16th-bit edge (latency 1 clk); payload counter +1.
REQ-018 Completed word, payload counter == SYNC_INTERVAL: word compared to SYNC_WORD; match -> miss counter 0; mismatch -> sync_err pulse, miss counter +1; no pdata_valid either way; payload counter 0.
REQ-019 Miss counter reaching MAX_MISS shall return the FSM to HUNT next cycle with window cleared; locked deasserts same cycle.
REQ-020 A payload word equal to SYNC_WORD shall be delivered as data (no in-band stripping).
REQ-021 sdata_valid low on a 16th-bit cycle shall delay completion; no partial word is ever output.
REQ-022 Bit counter wraps 15 -> 0; payload counter wraps SYNC_INTERVAL -> 0; word_cnt wraps 16'hFFFF -> 0; err_cnt saturates at 8'hFF.
REQ-023 pdata_valid and sync_err shall never be high together.

Reset
REQ-024 reset_n low: pdata=0, pdata_valid=0, locked=0, sync_err=0, word_cnt=0, err_cnt=0, all counters and window 0, state HUNT.
REQ-025 Reset asserted mid-word or mid-frame shall discard the partial word; after release, lock requires a fresh sync match.

Configuration
REQ-026 Macro DESER_STATS_EN defined: word_cnt increments per pdata_valid, err_cnt per sync_err.
REQ-027 DESER_STATS_EN undefined: no counter registers; word_cnt and err_cnt tied to 0; all other behaviour identical.

Structure
REQ-028 Package serdes_pkg shall hold the state typedef deser_state_t {HUNT, LOCKED}, DEFAULT_SYNC_WORD, and word width constant SERDES_W = 16.
REQ-029 One sub-module sync_detector (shift window + compare) shall be instantiated; counters and FSM in deserializer.

Verification
REQ-030 Stream 16'hBC1C then 8 words 16'h0001..16'h0008 then 16'hBC1C -> locked=1, 8 pdata_valid pulses with 0001..0008, no sync_err.
REQ-031 3 random bits then 16'hBC1C then 16'hA5A5 -> lock on bit alignment, pdata=16'hA5A5 one clk after its last bit.
REQ-032 Locked, 3 consecutive sync slots carry 16'h0000 -> 3 sync_err pulses, locked=0 one clk after the third; err_cnt=3 with DESER_STATS_EN.
REQ-033 sdata_valid toggled 1/0 per cycle across a word 16'h1234 -> single pdata_valid, pdata=16'h1234.
REQ-034 reset_n pulsed low after 9 bits of a payload word -> all outputs 0, HUNT; next data word ignored until 16'hBC1C seen.
REQ-035 Payload word 16'hBC1C inside a frame -> delivered with pdata_valid, payload counter advances, lock unaffected.
